// File: rtl/exec_shift_seq_pkg.sv
// rtl/exec_shift_seq_pkg.sv - shared encodings and defaults for the shift sequencer
// Purpose : shift/rotate op codes, sequencer state encoding, default chunk limits.
package exec_shift_seq_pkg;

    // Low three bits of the shift function code presented to exec_shift.
    typedef enum logic [2:0] {
        SH_ROL = 3'd0,
        SH_ROR = 3'd1,
        SH_RCL = 3'd2,
        SH_RCR = 3'd3,
        SH_SHL = 3'd4,
        SH_SHR = 3'd5,
        SH_SAL = 3'd6,
        SH_SAR = 3'd7
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    localparam int CNT_W_DEF = 8;
    // exec_shift handles at most 15 positions on a word and 7 on a byte.
    localparam int WSTEP_DEF = 15;
    localparam int BSTEP_DEF = 7;

endpackage

// File: rtl/exec_shift_seq.sv
// rtl/exec_shift_seq.sv - multi-cycle chunking sequencer in front of exec_shift
// Purpose : splits an 8086 shift/rotate of 0..255 positions into chunks that
//           exec_shift can perform, feeds each chunk result back in, and returns
//           the final result and flags to the execute unit.
// Ports   : iClk/iRstn         clock, asynchronous active-low reset
//           iStart/iFlush      request (IDLE only) / abort to IDLE
//           iFunc/iBW/iESel    op code, word/byte, count source (CL or 1)
//           iData/iCount       operand, CL value
//           iCarry/iOvf        incoming CF/OF
//           oShf*              chunk request to exec_shift
//           iShfOut/iShfC/iShfO chunk result from exec_shift
//           oBusy/oDone        RUN or DONE / one-cycle completion pulse
//           oResult/oCarry/oOvf/oFlagWe  final result, flags, flag write enable
module exec_shift_seq
    import exec_shift_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WSTEP = WSTEP_DEF,
    parameter int BSTEP = BSTEP_DEF
) (
    input  logic             iClk,
    input  logic             iRstn,
    input  logic             iStart,
    input  logic             iFlush,
    input  logic [3:0]       iFunc,
    input  logic             iBW,
    input  logic             iESel,
    input  logic [15:0]      iData,
    input  logic [CNT_W-1:0] iCount,
    input  logic             iCarry,
    input  logic             iOvf,
    output logic [3:0]       oShfFunc,
    output logic             oShfBW,
    output logic             oShfESel,
    output logic [15:0]      oShfData,
    output logic [4:0]       oShfAmt,
    output logic             oShfCarry,
    input  logic [15:0]      iShfOut,
    input  logic             iShfC,
    input  logic             iShfO,
    output logic             oBusy,
    output logic             oDone,
    output logic [15:0]      oResult,
    output logic             oCarry,
    output logic             oOvf,
    output logic             oFlagWe
);

    localparam logic [CNT_W-1:0] WSTEP_C = CNT_W'(WSTEP);
    localparam logic [CNT_W-1:0] BSTEP_C = CNT_W'(BSTEP);

    seq_state_e       state_q;
    logic [3:0]       func_q;
    logic             bw_q;
    logic [15:0]      data_q;
    logic             carry_q;
    logic             ovf_q;
    logic [CNT_W-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      res_q;
    logic             res_c_q;
    logic             res_o_q;
    logic             flag_we_q;

    logic             run;
    logic [CNT_W-1:0] step_max;
    logic [4:0]       amt;
    logic [CNT_W-1:0] rem_d;
    logic [CNT_W-1:0] rem_start;
    logic [15:0]      data_start;
    logic [15:0]      shf_res;

    assign run = (state_q == ST_RUN);

    // Chunk size: whatever is left, capped at what exec_shift can do in one pass.
    always_comb begin
        step_max = bw_q ? WSTEP_C : BSTEP_C;
        amt      = (rem_q < step_max) ? 5'(rem_q) : 5'(step_max);
        rem_d    = rem_q - CNT_W'(amt);
    end

    assign rem_start  = iESel ? iCount : CNT_W'(1);
    // Byte operands are held zero-extended so the result needs no further masking.
    assign data_start = iBW ? iData : {8'h00, iData[7:0]};
    assign shf_res    = bw_q ? iShfOut : {8'h00, iShfOut[7:0]};

    // The exec_shift bus is forced to zero outside RUN so it is quiet at reset and idle.
    assign oShfFunc  = run ? func_q  : 4'h0;
    assign oShfBW    = run ? bw_q    : 1'b0;
    assign oShfESel  = run;
    assign oShfData  = run ? data_q  : 16'h0000;
    assign oShfAmt   = run ? amt     : 5'd0;
    assign oShfCarry = run ? carry_q : 1'b0;

    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oResult = res_q;
    assign oCarry  = res_c_q;
    assign oOvf    = res_o_q;
    assign oFlagWe = flag_we_q;

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q   <= ST_IDLE;
            func_q    <= 4'h0;
            bw_q      <= 1'b0;
            data_q    <= 16'h0000;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= 16'h0000;
            res_c_q   <= 1'b0;
            res_o_q   <= 1'b0;
            flag_we_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (iFlush) begin
                // Abort leaves the previously delivered result visible.
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (iStart) begin
                            func_q  <= iFunc;
                            bw_q    <= iBW;
                            data_q  <= data_start;
                            carry_q <= iCarry;
                            ovf_q   <= iOvf;
                            rem_q   <= rem_start;
                            busy_q  <= 1'b1;
                            if (rem_start == '0) begin
                                // Zero count: operand and flags pass through untouched.
                                state_q   <= ST_DONE;
                                done_q    <= 1'b1;
                                res_q     <= data_start;
                                res_c_q   <= iCarry;
                                res_o_q   <= iOvf;
                                flag_we_q <= 1'b0;
                            end else begin
                                state_q <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        data_q  <= shf_res;
                        carry_q <= iShfC;
                        ovf_q   <= iShfO;
                        rem_q   <= rem_d;
                        if (rem_d == '0) begin
                            state_q   <= ST_DONE;
                            done_q    <= 1'b1;
                            res_q     <= shf_res;
                            res_c_q   <= iShfC;
                            res_o_q   <= iShfO;
                            flag_we_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Working OF is only observed through the final chunk's iShfO.
    logic unused_ok;
    assign unused_ok = ovf_q;

endmodule

// File: tb/tb_exec_shift_seq.sv
// tb/tb_exec_shift_seq.sv - self-checking bench for exec_shift_seq
module tb_exec_shift_seq;
    import exec_shift_seq_pkg::*;

    logic        iClk = 1'b0;
    logic        iRstn = 1'b0;
    logic        iStart = 1'b0;
    logic        iFlush = 1'b0;
    logic [3:0]  iFunc = 4'h0;
    logic        iBW = 1'b0;
    logic        iESel = 1'b0;
    logic [15:0] iData = 16'h0;
    logic [7:0]  iCount = 8'h0;
    logic        iCarry = 1'b0;
    logic        iOvf = 1'b0;
    logic [3:0]  oShfFunc;
    logic        oShfBW;
    logic        oShfESel;
    logic [15:0] oShfData;
    logic [4:0]  oShfAmt;
    logic        oShfCarry;
    logic [15:0] iShfOut;
    logic        iShfC;
    logic        iShfO;
    logic        oBusy;
    logic        oDone;
    logic [15:0] oResult;
    logic        oCarry;
    logic        oOvf;
    logic        oFlagWe;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        c;
        logic        o;
    } sres_t;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        o;
        logic        we;
        int          lat;
        logic        chk_o;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] last_res;
    sres_t       env_r;

    always #5 iClk = ~iClk;

    exec_shift_seq dut (
        .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iFlush(iFlush),
        .iFunc(iFunc), .iBW(iBW), .iESel(iESel), .iData(iData),
        .iCount(iCount), .iCarry(iCarry), .iOvf(iOvf),
        .oShfFunc(oShfFunc), .oShfBW(oShfBW), .oShfESel(oShfESel),
        .oShfData(oShfData), .oShfAmt(oShfAmt), .oShfCarry(oShfCarry),
        .iShfOut(iShfOut), .iShfC(iShfC), .iShfO(iShfO),
        .oBusy(oBusy), .oDone(oDone), .oResult(oResult),
        .oCarry(oCarry), .oOvf(oOvf), .oFlagWe(oFlagWe)
    );

    // Reference 8086 shift: n single-position steps; OF is that of the last step.
    function automatic sres_t shift_n(input logic [2:0] f, input logic bw,
                                      input logic [15:0] din, input logic cin,
                                      input logic oin, input int n);
        sres_t       r;
        logic [15:0] d, mask, topb;
        logic        c, o, msb, lsb, nmsb, nnext;
        mask = bw ? 16'hFFFF : 16'h00FF;
        topb = bw ? 16'h8000 : 16'h0080;
        d = din & mask;
        c = cin;
        o = oin;
        for (int i = 0; i < n; i++) begin
            msb = (d & topb) != 16'h0;
            lsb = d[0];
            case (f)
                3'd0: begin d = ((d << 1) | {15'h0, msb}) & mask; c = msb; end
                3'd1: begin d = (d >> 1) | (lsb ? topb : 16'h0); c = lsb; end
                3'd2: begin d = ((d << 1) | {15'h0, c}) & mask; c = msb; end
                3'd3: begin d = (d >> 1) | (c ? topb : 16'h0); c = lsb; end
                3'd5: begin d = d >> 1; c = lsb; end
                3'd7: begin d = (d >> 1) | (msb ? topb : 16'h0); c = lsb; end
                default: begin d = (d << 1) & mask; c = msb; end
            endcase
            nmsb  = (d & topb) != 16'h0;
            nnext = (d & (topb >> 1)) != 16'h0;
            case (f)
                3'd1, 3'd3: o = nmsb ^ nnext;
                3'd5:       o = msb;
                3'd7:       o = 1'b0;
                default:    o = nmsb ^ c;
            endcase
        end
        r.d = d;
        r.c = c;
        r.o = o;
        return r;
    endfunction

    // Stand-in for the exec_shift stage that the parent places beside the sequencer.
    assign env_r   = shift_n(oShfFunc[2:0], oShfBW, oShfData, oShfCarry, 1'b0, int'(oShfAmt));
    assign iShfOut = env_r.d;
    assign iShfC   = env_r.c;
    assign iShfO   = env_r.o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic bw,
                          input logic esel, input logic [15:0] d, input logic [7:0] cnt,
                          input logic c, input logic o,
                          output logic [15:0] r_obs, output logic c_obs);
        exp_t  e;
        sres_t m;
        int    n, smax, lat;
        n    = esel ? int'(cnt) : 1;
        smax = bw ? 15 : 7;
        if (n == 0) begin
            e.res = bw ? d : {8'h00, d[7:0]};
            e.c = c; e.o = o; e.we = 1'b0; e.lat = 1; e.chk_o = 1'b1;
        end else begin
            m = shift_n(f, bw, d, c, o, n);
            e.res = m.d; e.c = m.c; e.o = m.o; e.we = 1'b1;
            e.lat = (n + smax - 1) / smax + 1;
            e.chk_o = (n == 1);
        end
        sb.push_back(e);
        @(negedge iClk);
        iFunc = {1'b0, f}; iBW = bw; iESel = esel; iData = d; iCount = cnt;
        iCarry = c; iOvf = o; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        lat = 1;
        if (n != 0) begin
            check({tag, " busy"}, 32'(oBusy), 32'd1);
            check({tag, " shf_esel"}, 32'(oShfESel), 32'd1);
        end
        while (!oDone && lat < 300) begin
            @(negedge iClk);
            lat++;
        end
        e = sb.pop_front();
        check({tag, " done"}, 32'(oDone), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " result"}, 32'(oResult), 32'(e.res));
        check({tag, " cf"}, 32'(oCarry), 32'(e.c));
        if (e.chk_o) check({tag, " of"}, 32'(oOvf), 32'(e.o));
        check({tag, " flag_we"}, 32'(oFlagWe), 32'(e.we));
        r_obs = oResult;
        c_obs = oCarry;
        last_res = e.res;
        @(negedge iClk);
        check({tag, " done_pulse"}, 32'(oDone), 32'd0);
    endtask

    initial begin
        logic [15:0] r;
        logic        cf;
        int          seen;
        logic [7:0]  bcnt[8];
        bcnt[0] = 8'd0;  bcnt[1] = 8'd1;  bcnt[2] = 8'd7;   bcnt[3] = 8'd8;
        bcnt[4] = 8'd15; bcnt[5] = 8'd16; bcnt[6] = 8'd17;  bcnt[7] = 8'd255;

        #12;
        check("rst busy", 32'(oBusy), 32'd0);
        check("rst done", 32'(oDone), 32'd0);
        check("rst result", 32'(oResult), 32'd0);
        check("rst shf_bus", 32'({oShfFunc, oShfBW, oShfESel, oShfData, oShfAmt, oShfCarry}), 32'd0);
        check("rst flags", 32'({oCarry, oOvf, oFlagWe}), 32'd0);
        @(negedge iClk);
        iRstn = 1'b1;

        run_op("t1 shl1", SH_SHL, 1'b1, 1'b0, 16'h8001, 8'd0, 1'b0, 1'b0, r, cf);
        check("t1 spec result", 32'(r), 32'h0002);
        check("t1 spec cf", 32'(cf), 32'd1);
        check("t1 spec of", 32'(oOvf), 32'd1);
        run_op("t2 rol0", SH_ROL, 1'b1, 1'b1, 16'hBEEF, 8'd0, 1'b1, 1'b1, r, cf);
        check("t2 spec result", 32'(r), 32'hBEEF);
        check("t2 spec of", 32'(oOvf), 32'd1);
        run_op("t3 shr16", SH_SHR, 1'b1, 1'b1, 16'h8000, 8'd16, 1'b0, 1'b0, r, cf);
        check("t3 spec result", 32'(r), 32'h0000);
        check("t3 spec cf", 32'(cf), 32'd1);
        run_op("t4 rcl9", SH_RCL, 1'b0, 1'b1, 16'h0080, 8'd9, 1'b0, 1'b0, r, cf);
        check("t4 spec result", 32'(r), 32'h0080);
        check("t4 spec cf", 32'(cf), 32'd0);
        run_op("t5 rol255", SH_ROL, 1'b1, 1'b1, 16'h1234, 8'd255, 1'b0, 1'b0, r, cf);
        check("t5 spec result", 32'(r), 32'h091A);
        check("t5 spec cf", 32'(cf), 32'd0);
        run_op("sar byte", SH_SAR, 1'b0, 1'b1, 16'hFF90, 8'd10, 1'b0, 1'b0, r, cf);
        check("sar spec result", 32'(r), 32'h00FF);

        // Flush in RUN cycle 3 with extra starts during RUN.
        begin
            exp_t e;
            logic [15:0] prev;
            prev = last_res;
            e.res = 16'h0; e.c = 1'b0; e.o = 1'b0; e.we = 1'b0; e.lat = 0; e.chk_o = 1'b0;
            sb.push_back(e);
            @(negedge iClk);
            iFunc = {1'b0, SH_ROL}; iBW = 1'b1; iESel = 1'b1; iData = 16'h1234;
            iCount = 8'd255; iStart = 1'b1;
            @(negedge iClk);
            iData = 16'h5555; iCount = 8'd0;
            @(negedge iClk);
            check("flush busy_run", 32'(oBusy), 32'd1);
            @(negedge iClk);
            iStart = 1'b0; iFlush = 1'b1;
            @(negedge iClk);
            iFlush = 1'b0;
            check("flush idle", 32'(oBusy), 32'd0);
            check("flush shf_esel", 32'(oShfESel), 32'd0);
            seen = 0;
            for (int i = 0; i < 24; i++) begin
                @(negedge iClk);
                if (oDone || oBusy) seen++;
            end
            check("flush no_done", 32'(seen), 32'd0);
            check("flush result_hold", 32'(oResult), 32'(prev));
            e = sb.pop_front();
        end

        for (int k = 0; k < 16; k++) begin
            logic [2:0]  f;
            logic        bw, es, c;
            logic [15:0] d;
            logic [7:0]  cnt;
            f   = 3'($urandom_range(0, 7));
            bw  = 1'($urandom_range(0, 1));
            es  = (k % 4) != 3;
            c   = 1'($urandom_range(0, 1));
            d   = 16'($urandom);
            cnt = (k < 8) ? bcnt[k] : 8'($urandom_range(0, 40));
            run_op($sformatf("rnd%0d", k), f, bw, es, d, cnt, c, 1'b0, r, cf);
        end

        // Asynchronous reset in the middle of RUN.
        @(negedge iClk);
        iFunc = {1'b0, SH_SHL}; iBW = 1'b1; iESel = 1'b1; iData = 16'hA5A5;
        iCount = 8'd200; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        @(negedge iClk);
        @(negedge iClk);
        #2 iRstn = 1'b0;
        #1;
        check("arst busy", 32'(oBusy), 32'd0);
        check("arst shf_bus", 32'({oShfESel, oShfData, oShfAmt, oShfCarry}), 32'd0);
        check("arst result", 32'({oResult, oCarry, oOvf, oFlagWe, oDone}), 32'd0);
        @(negedge iClk);
        iRstn = 1'b1;
        run_op("post_rst ror1", SH_ROR, 1'b0, 1'b0, 16'h0001, 8'd0, 1'b0, 1'b0, r, cf);
        check("post_rst spec result", 32'(r), 32'h0080);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
